ps2_ace_keyboard: RTL
=====================

PS2_ACE_KEYBOARD -- requirements
Module: ps2_ace_keyboard

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65000, the idle clocks after which a partial PS/2 frame is aborted.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port ps2_clk, input, 1 bit: raw PS/2 clock from the keyboard, asynchronous.
REQ-005 SHALL have port ps2_data, input, 1 bit: raw PS/2 data, asynchronous.
REQ-006 SHALL have port rows, input, 8 bits: active-low row select, driven from CPU address bits 15:8.
REQ-007 SHALL have port columns, output, 5 bits: active-low key columns to the keyboard logic; 0 means pressed.
REQ-008 SHALL have port code_valid, output, 1 bit: one-clock pulse for each accepted scancode byte.
REQ-009 SHALL have port code, output, 8 bits: the last accepted scancode byte, held until the next byte is accepted.

Function
REQ-010 SHALL pass ps2_clk and ps2_data through 2-flop synchronisers and sample data on the synchronised ps2_clk falling edge.
REQ-011 SHALL run a receive FSM: IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE.
REQ-012 SHALL leave IDLE only on a falling edge where data is 0 (start bit); data 1 at that edge is ignored.
REQ-013 SHALL accept the byte in STOP only if the stop bit is 1: code_valid pulses one clock later and code updates in the same cycle.
REQ-014 SHALL discard the frame and return to IDLE if the stop bit is 0.
REQ-015 SHALL abort to IDLE, discarding the frame, if TIMEOUT_CYCLES clocks pass without a falling edge while outside IDLE.
REQ-016 SHALL, on byte F0, set a break flag; on E0, set an extended flag; neither byte changes the matrix.
REQ-017 SHALL, on any other byte, set the mapped key (release if break flag is set), then clear both flags.
REQ-018 SHALL hold a 40-bit pressed matrix of 8 rows x 5 columns; column 0 is the first key of each row.
REQ-019 SHALL map row 0 as: LShift 12 or RShift 59 = SHIFT; LCtrl 14 = SYMSHIFT; Z 1A, X 22, C 21.
REQ-020 SHALL map row 1 as: A 1C, S 1B, D 23, F 2B, G 34.
REQ-021 SHALL map row 2 as: Q 15, W 1D, E 24, R 2D, T 2C.
REQ-022 SHALL map row 3 as: 1 16, 2 1E, 3 26, 4 25, 5 2E.
REQ-023 SHALL map row 4 as: 0 45, 9 46, 8 3E, 7 3D, 6 36.
REQ-024 SHALL map row 5 as: P 4D, O 44, I 43, U 3C, Y 35.
REQ-025 SHALL map row 6 as: Enter 5A, L 4B, K 42, J 3B, H 33.
REQ-026 SHALL map row 7 as: Space 29, M 3A, N 31, B 32, V 2A.
REQ-027 SHALL map E0-prefixed codes as: E0 14 = SYMSHIFT, E0 5A = ENTER; all other E0 codes and all unmapped codes change nothing.
REQ-028 SHALL register columns[c] each clock as 0 when any row r with rows[r]=0 has key (r,c) pressed, otherwise 1; latency is one clock.
REQ-029 SHALL drive columns as 5'b11111 when rows is all ones.
REQ-030 SHALL make a repeated make code for an already-pressed key, or a break for a released key, a no-op.
REQ-031 SHALL place no ordering constraint between keys: any combination, including all 40, may be held at once.

Reset
REQ-032 SHALL, on reset, set: FSM to IDLE, bit and timeout counters to 0, break and extended flags clear, matrix all released, columns 5'b11111, code 8'h00, code_valid 0.
REQ-033 SHALL, on reset mid-frame, discard the partial byte; the first frame after reset is received normally.

Configuration
REQ-034 SHALL, with PS2_PARITY_CHECK_EN defined, accept a byte only if data plus the parity bit has an odd number of ones; otherwise it discards the frame with no code_valid and no matrix change.
REQ-035 SHALL, without PS2_PARITY_CHECK_EN, sample the parity bit but ignore its value.

Verification
REQ-036 SHALL cover: send 1C, rows=8'hFD -> code_valid pulse with code=8'h1C, columns=5'b11110; then send F0 1C -> columns=5'b11111.
REQ-037 SHALL cover: send 12 and 45, rows=8'hEE -> columns=5'b11110; with rows=8'hFE -> 5'b11110; with rows=8'hEF -> 5'b11110; release 12, rows=8'hFE -> 5'b11111.
REQ-038 SHALL cover: send E0 14, rows=8'hFE -> columns=5'b11101; send E0 F0 14 -> 5'b11111; send E0 75 -> matrix unchanged.
REQ-039 SHALL cover, with PS2_PARITY_CHECK_EN defined: send 1C with even parity -> no code_valid and columns stays 5'b11111; without the macro -> key A is pressed.
REQ-040 SHALL cover: stop ps2_clk after 4 data bits for TIMEOUT_CYCLES+1 clocks, then send a full 1B -> only 1B is accepted, and rows=8'hFD gives columns=5'b11101.
REQ-041 SHALL cover: assert reset with A held and mid-frame -> columns=5'b11111 and code=8'h00 the next clock.

Source files
------------

// File: rtl/ps2_ace_keyboard.sv
// PS/2 receiver feeding an 8x5 Jupiter Ace style key matrix scanned by rows.
// Define PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_ace_keyboard #(
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic [7:0] rows,
  output logic [4:0] columns,
  output logic       code_valid,
  output logic [7:0] code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t         state, state_nx;
  logic [2:0]     clk_sync;
  logic [1:0]     dat_sync;
  logic [2:0]     bit_cnt;
  logic [7:0]     shreg;
  logic           par_bit;
  logic [TW-1:0]  to_cnt;
  logic           fall, bit_in, par_ok, accept, timeout;
  logic           brk_flag, ext_flag;
  logic [7:0][4:0] mat;
  logic           key_hit;
  logic [5:0]     key_pos;
  logic [4:0]     col_nx;

  assign fall   = clk_sync[2] & ~clk_sync[1];
  assign bit_in = dat_sync[1];

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shreg, par_bit};
`else
  logic par_unused;
  assign par_unused = par_bit;
  assign par_ok = 1'b1;
`endif

  assign timeout = (state != S_IDLE) && !fall &&
                   (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    if (timeout) begin
      state_nx = S_IDLE;
    end else if (fall) begin
      unique case (state)
        S_IDLE:   if (!bit_in) state_nx = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_nx = S_PARITY;
        S_PARITY: state_nx = S_STOP;
        S_STOP: begin
          state_nx = S_IDLE;
          accept   = bit_in & par_ok;
        end
        default:  state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      clk_sync <= '1;
      dat_sync <= '1;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      to_cnt   <= '0;
    end else begin
      clk_sync <= {clk_sync[1:0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      state    <= state_nx;
      to_cnt   <= (state == S_IDLE || fall) ? '0 : to_cnt + 1'b1;
      if (fall) begin
        unique case (state)
          S_IDLE: bit_cnt <= '0;
          S_DATA: begin
            shreg   <= {bit_in, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          S_PARITY: par_bit <= bit_in;
          default: ;
        endcase
      end
    end
  end

  // key_pos is {row, column} as two octal digits
  always_comb begin
    key_hit = 1'b1;
    key_pos = 6'o00;
    if (ext_flag) begin
      unique case (shreg)
        8'h14:   key_pos = 6'o01;
        8'h5A:   key_pos = 6'o60;
        default: key_hit = 1'b0;
      endcase
    end else begin
      unique case (shreg)
        8'h12, 8'h59: key_pos = 6'o00;
        8'h14: key_pos = 6'o01;
        8'h1A: key_pos = 6'o02;
        8'h22: key_pos = 6'o03;
        8'h21: key_pos = 6'o04;
        8'h1C: key_pos = 6'o10;
        8'h1B: key_pos = 6'o11;
        8'h23: key_pos = 6'o12;
        8'h2B: key_pos = 6'o13;
        8'h34: key_pos = 6'o14;
        8'h15: key_pos = 6'o20;
        8'h1D: key_pos = 6'o21;
        8'h24: key_pos = 6'o22;
        8'h2D: key_pos = 6'o23;
        8'h2C: key_pos = 6'o24;
        8'h16: key_pos = 6'o30;
        8'h1E: key_pos = 6'o31;
        8'h26: key_pos = 6'o32;
        8'h25: key_pos = 6'o33;
        8'h2E: key_pos = 6'o34;
        8'h45: key_pos = 6'o40;
        8'h46: key_pos = 6'o41;
        8'h3E: key_pos = 6'o42;
        8'h3D: key_pos = 6'o43;
        8'h36: key_pos = 6'o44;
        8'h4D: key_pos = 6'o50;
        8'h44: key_pos = 6'o51;
        8'h43: key_pos = 6'o52;
        8'h3C: key_pos = 6'o53;
        8'h35: key_pos = 6'o54;
        8'h5A: key_pos = 6'o60;
        8'h4B: key_pos = 6'o61;
        8'h42: key_pos = 6'o62;
        8'h3B: key_pos = 6'o63;
        8'h33: key_pos = 6'o64;
        8'h29: key_pos = 6'o70;
        8'h3A: key_pos = 6'o71;
        8'h31: key_pos = 6'o72;
        8'h32: key_pos = 6'o73;
        8'h2A: key_pos = 6'o74;
        default: key_hit = 1'b0;
      endcase
    end
  end

  always_comb begin
    col_nx = '1;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (!rows[r] && mat[r][c]) col_nx[c] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code       <= '0;
      code_valid <= 1'b0;
      brk_flag   <= 1'b0;
      ext_flag   <= 1'b0;
      mat        <= '0;
      columns    <= '1;
    end else begin
      columns    <= col_nx;
      code_valid <= accept;
      if (accept) begin
        code <= shreg;
        if (shreg == 8'hF0) begin
          brk_flag <= 1'b1;
        end else if (shreg == 8'hE0) begin
          ext_flag <= 1'b1;
        end else begin
          if (key_hit) mat[key_pos[5:3]][key_pos[2:0]] <= ~brk_flag;
          brk_flag <= 1'b0;
          ext_flag <= 1'b0;
        end
      end
    end
  end

endmodule
